// File: rtl/ysyx_22050019_booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for the EXU multiply path.
// Covers mul/mulh/mulhsu/mulhu/mulw. Width and digits retired per cycle are
// parameters. The optional early exit stops once the remaining multiplier
// bits can only produce zero digits.
module ysyx_22050019_booth_mul_iter #(
    parameter int XLEN           = 64,
    parameter int DIGITS_PER_CYC = 1,
    parameter int EARLY_EXIT     = 1
) (
    input  logic            clk,
    input  logic            rst_n,      // active-high synchronous reset despite the name
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      mul_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int W  = 2 * XLEN + 2;                      // accumulator / multiplicand width
    localparam int M  = XLEN + 3;                          // multiplier register width
    localparam int N  = (XLEN + 2) / 2;                    // Booth digits for a full product
    localparam int CW = $clog2(N + DIGITS_PER_CYC + 1);    // digit counter width

    localparam logic [4:0] OP_MUL    = 5'b00001;
    localparam logic [4:0] OP_MULH   = 5'b00010;
    localparam logic [4:0] OP_MULHSU = 5'b00100;
    localparam logic [4:0] OP_MULHU  = 5'b01000;
    localparam logic [4:0] OP_MULW   = 5'b10000;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [W-1:0]           acc_reg, mcand_reg;
    logic [M-1:0]           mplier_reg;
    logic [CW-1:0]          cnt_reg;
    logic [4:0]             op_reg;
    logic [XLEN-1:0]        result_reg;

    logic                   accept;
    logic [XLEN-1:0]        a_in, b_in;
    logic                   a_signed, b_signed;
    logic [XLEN:0]          a_ext, b_ext;
    logic [DIGITS_PER_CYC-1:0][W-1:0] pp;
    logic [W-1:0]           acc_next;
    logic [M-1:0]           mplier_next;
    logic [CW-1:0]          cnt_next;
    logic                   calc_last;
    logic [XLEN-1:0]        res_sel;

    // One Booth partial product: 0, +-B or +-2B, negation in two's complement.
    function automatic logic [W-1:0] booth_pp(input logic [2:0] code, input logic [W-1:0] b);
        case (code)
            3'b001, 3'b010: booth_pp = b;
            3'b011:         booth_pp = b << 1;
            3'b100:         booth_pp = ~(b << 1) + W'(1);
            3'b101, 3'b110: booth_pp = ~b + W'(1);
            default:        booth_pp = '0;
        endcase
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = !flush && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;

    // MULW only looks at the low word; on a 32-bit datapath there is nothing to mask.
    generate
        if (XLEN == 64) begin : g_mulw_mask
            assign a_in = (mul_op == OP_MULW) ? {32'b0, src1[31:0]} : src1;
            assign b_in = (mul_op == OP_MULW) ? {32'b0, src2[31:0]} : src2;
        end else begin : g_no_mask
            assign a_in = src1;
            assign b_in = src2;
        end
    endgenerate

    assign a_signed = (mul_op == OP_MUL) || (mul_op == OP_MULH) || (mul_op == OP_MULHSU);
    assign b_signed = (mul_op == OP_MUL) || (mul_op == OP_MULH);
    assign a_ext    = {a_signed & a_in[XLEN-1], a_in};
    assign b_ext    = {b_signed & b_in[XLEN-1], b_in};

    // Digit gi looks at its own overlapping 3-bit window and a multiplicand pre-shifted by 2*gi.
    generate
        for (genvar gi = 0; gi < DIGITS_PER_CYC; gi++) begin : g_pp
            assign pp[gi] = booth_pp(mplier_reg[2*gi +: 3], mcand_reg << (2 * gi));
        end
    endgenerate

    // Accumulate this cycle's partial products and work out whether CALC is finished.
    always_comb begin
        acc_next = acc_reg;
        for (int j = 0; j < DIGITS_PER_CYC; j++) begin
            acc_next = acc_next + pp[j];
        end
        mplier_next = $signed(mplier_reg) >>> (2 * DIGITS_PER_CYC);
        cnt_next    = cnt_reg + CW'(DIGITS_PER_CYC);
        // All-zero or all-one remaining multiplier yields only zero digits from here on.
        calc_last   = (cnt_next >= CW'(N)) ||
                      ((EARLY_EXIT != 0) && ((mplier_next == '0) || (mplier_next == '1)));
    end

    // Pick the product slice for the latched operation from the final accumulator.
    always_comb begin
        res_sel = '0;
        case (op_reg)
            OP_MUL:                       res_sel = acc_next[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_sel = acc_next[2*XLEN-1:XLEN];
            OP_MULW:                      if (XLEN == 64) res_sel = XLEN'($signed(acc_next[31:0]));
            default:                      res_sel = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; flush wins over everything but reset.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) state_next = CALC;
                CALC: if (calc_last) state_next = DONE;
                DONE: if (out_ready) state_next = in_valid ? CALC : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: load on accept, iterate in CALC, capture the result on the last CALC cycle.
    always_ff @(posedge clk) begin
        if (rst_n || flush) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            op_reg     <= '0;
            result_reg <= '0;
        end else if (accept) begin
            acc_reg    <= '0;
            mcand_reg  <= {{(XLEN+1){a_ext[XLEN]}}, a_ext};
            mplier_reg <= {b_ext[XLEN], b_ext, 1'b0};
            cnt_reg    <= '0;
            op_reg     <= mul_op;
        end else if (state_reg == CALC) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << (2 * DIGITS_PER_CYC);
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            if (calc_last) result_reg <= res_sel;
        end
    end
endmodule
